pixel_accumulator: RTL and testbench

Producer side of the centroid-update interface. Accepts a stream of labelled RGB pixels, one per cycle, and accumulates per-cluster component sums and pixel counts. At frame end it presents stable sums and counts, plus a cluster-enable mask, to pixel_divider. It holds them until the divider reports final_ready, then returns to idle for the next iteration.

---
 rtl/kmeans_pkg.sv | 22 ++
 rtl/cluster_accum_lane.sv | 75 +++++++
 rtl/pixel_accumulator.sv | 110 +++++++++++
 tb/tb_pixel_accumulator.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared widths, FSM encoding and lane-slicing helper for the k-means
// centroid-update datapath (pixel_accumulator and pixel_divider).
package kmeans_pkg;

    localparam int NUM_CLUSTERS = 16;
    localparam int PIX_W        = 8;
    localparam int ACC_W        = 20;
    localparam int CNT_W        = 12;
    localparam int ID_W         = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Low bit index of lane `lane` inside a flattened bus of `width`-bit lanes.
    function automatic int slice_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/cluster_accum_lane.sv
// One cluster lane: R/G/B component sums plus a saturating pixel count.
// A hit on a saturated lane is dropped entirely and reported through sat.
module cluster_accum_lane
    import kmeans_pkg::*;
#(
    parameter int PIX_W_P = PIX_W,
    parameter int ACC_W_P = ACC_W,
    parameter int CNT_W_P = CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               clear,
    input  logic               hit,
    input  logic [PIX_W_P-1:0] pix_r,
    input  logic [PIX_W_P-1:0] pix_g,
    input  logic [PIX_W_P-1:0] pix_b,
    output logic [ACC_W_P-1:0] sum_r,
    output logic [ACC_W_P-1:0] sum_g,
    output logic [ACC_W_P-1:0] sum_b,
    output logic [CNT_W_P-1:0] cnt,
    output logic               sat,
    output logic               nonzero
);

    localparam logic [CNT_W_P-1:0] CNT_MAX = '1;

    logic [ACC_W_P-1:0] sum_r_q, sum_r_d;
    logic [ACC_W_P-1:0] sum_g_q, sum_g_d;
    logic [ACC_W_P-1:0] sum_b_q, sum_b_d;
    logic [CNT_W_P-1:0] cnt_q,   cnt_d;

    assign sat     = (cnt_q == CNT_MAX);
    assign nonzero = (cnt_q != '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sum_r_d = sum_r_q;
        sum_g_d = sum_g_q;
        sum_b_d = sum_b_q;
        cnt_d   = cnt_q;
        if (clear) begin
            sum_r_d = '0;
            sum_g_d = '0;
            sum_b_d = '0;
            cnt_d   = '0;
        end else if (hit && !sat) begin
            sum_r_d = sum_r_q + ACC_W_P'(pix_r);
            sum_g_d = sum_g_q + ACC_W_P'(pix_g);
            sum_b_d = sum_b_q + ACC_W_P'(pix_b);
            cnt_d   = cnt_q + CNT_W_P'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            cnt_q   <= '0;
        end else if (ce) begin
            sum_r_q <= sum_r_d;
            sum_g_q <= sum_g_d;
            sum_b_q <= sum_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum_r = sum_r_q;
    assign sum_g = sum_g_q;
    assign sum_b = sum_b_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/pixel_accumulator.sv
// Accumulates labelled RGB pixels into per-cluster sums/counts over a frame,
// then holds them stable for pixel_divider until it reports final_ready.
module pixel_accumulator
    import kmeans_pkg::*;
#(
    parameter int NUM_CLUSTERS_P = NUM_CLUSTERS,
    parameter int PIX_W_P        = PIX_W,
    parameter int ACC_W_P        = ACC_W,
    parameter int CNT_W_P        = CNT_W,
    parameter int ID_W_P         = ID_W
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ce,
    input  logic                               start,
    input  logic                               pixel_valid,
    output logic                               pixel_ready,
    input  logic                               pixel_last,
    input  logic [PIX_W_P-1:0]                 pixel_r,
    input  logic [PIX_W_P-1:0]                 pixel_g,
    input  logic [PIX_W_P-1:0]                 pixel_b,
    input  logic [ID_W_P-1:0]                  pixel_id,
    input  logic                               div_ready,
    output logic                               accum_valid,
    output logic [NUM_CLUSTERS_P-1:0]          en,
    output logic [NUM_CLUSTERS_P*ACC_W_P-1:0]  red_accum,
    output logic [NUM_CLUSTERS_P*ACC_W_P-1:0]  green_accum,
    output logic [NUM_CLUSTERS_P*ACC_W_P-1:0]  blue_accum,
    output logic [NUM_CLUSTERS_P*CNT_W_P-1:0]  count,
    output logic                               overflow
);

    state_e state_q, state_d;
    logic   overflow_q, overflow_d;
    logic   accum_valid_q, accum_valid_d;
    logic   accept, clear;

    logic [NUM_CLUSTERS_P-1:0] lane_sat;
    logic [NUM_CLUSTERS_P-1:0] lane_nz;

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        clear      = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    overflow_d = 1'b0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (pixel_valid) begin
                    accept = 1'b1;
                    if (lane_sat[pixel_id]) overflow_d = 1'b1;
                    // A dropped last pixel still closes the frame.
                    if (pixel_last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (div_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accum_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            overflow_q    <= 1'b0;
            accum_valid_q <= 1'b0;
        end else if (ce) begin
            state_q       <= state_d;
            overflow_q    <= overflow_d;
            accum_valid_q <= accum_valid_d;
        end
    end

    for (genvar k = 0; k < NUM_CLUSTERS_P; k++) begin : g_lane
        cluster_accum_lane #(
            .PIX_W_P (PIX_W_P),
            .ACC_W_P (ACC_W_P),
            .CNT_W_P (CNT_W_P)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .ce      (ce),
            .clear   (clear),
            .hit     (accept && (pixel_id == ID_W_P'(k))),
            .pix_r   (pixel_r),
            .pix_g   (pixel_g),
            .pix_b   (pixel_b),
            .sum_r   (red_accum  [slice_lo(k, ACC_W_P) +: ACC_W_P]),
            .sum_g   (green_accum[slice_lo(k, ACC_W_P) +: ACC_W_P]),
            .sum_b   (blue_accum [slice_lo(k, ACC_W_P) +: ACC_W_P]),
            .cnt     (count      [slice_lo(k, CNT_W_P) +: CNT_W_P]),
            .sat     (lane_sat[k]),
            .nonzero (lane_nz[k])
        );
    end

    assign pixel_ready = (state_q == ACCUM);
    assign accum_valid = accum_valid_q;
    assign overflow    = overflow_q;
    assign en          = lane_nz;

endmodule

// File: tb/tb_pixel_accumulator.sv
// Self-checking bench for pixel_accumulator: directed test-plan steps plus a
// randomized frame, all compared against an array-based frame model.
module tb_pixel_accumulator;

    localparam int NC    = 16;
    localparam int PW    = 8;
    localparam int AW    = 20;
    localparam int CW    = 12;
    localparam int IW    = 4;
    localparam int M_IDLE = 0, M_ACCUM = 1, M_HOLD = 2;

    logic            clk = 1'b0;
    logic            reset, ce, start, pixel_valid, pixel_last, div_ready;
    logic [PW-1:0]   pixel_r, pixel_g, pixel_b;
    logic [IW-1:0]   pixel_id;
    logic            pixel_ready, accum_valid, overflow;
    logic [NC-1:0]   en;
    logic [NC*AW-1:0] red_accum, green_accum, blue_accum;
    logic [NC*CW-1:0] count;

    int passed = 0;
    int total  = 0;

    int unsigned m_r[NC], m_g[NC], m_b[NC], m_cnt[NC];
    bit          m_ovf;
    int          m_state;

    pixel_accumulator dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .start       (start),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_last  (pixel_last),
        .pixel_r     (pixel_r),
        .pixel_g     (pixel_g),
        .pixel_b     (pixel_b),
        .pixel_id    (pixel_id),
        .div_ready   (div_ready),
        .accum_valid (accum_valid),
        .en          (en),
        .red_accum   (red_accum),
        .green_accum (green_accum),
        .blue_accum  (blue_accum),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_r[k] = 0; m_g[k] = 0; m_b[k] = 0; m_cnt[k] = 0;
        end
        m_ovf   = 1'b0;
        m_state = M_IDLE;
    endtask

    // Frame-level behaviour for one enabled clock edge, from the current inputs.
    task automatic model_clock();
        if (!ce) return;
        if (m_state == M_IDLE) begin
            if (start) begin
                model_reset();
                m_state = M_ACCUM;
            end
        end else if (m_state == M_ACCUM) begin
            if (pixel_valid) begin
                if (m_cnt[pixel_id] == 4095) begin
                    m_ovf = 1'b1;
                end else begin
                    m_r[pixel_id] += pixel_r;
                    m_g[pixel_id] += pixel_g;
                    m_b[pixel_id] += pixel_b;
                    m_cnt[pixel_id] += 1;
                end
                if (pixel_last) m_state = M_HOLD;
            end
        end else begin
            if (div_ready) m_state = M_IDLE;
        end
    endtask

    function automatic logic [NC*AW-1:0] exp_sums(input int sel);
        logic [NC*AW-1:0] v;
        v = '0;
        for (int k = 0; k < NC; k++)
            v[k*AW +: AW] = AW'(sel == 0 ? m_r[k] : (sel == 1 ? m_g[k] : m_b[k]));
        return v;
    endfunction

    function automatic logic [NC*CW-1:0] exp_counts();
        logic [NC*CW-1:0] v;
        v = '0;
        for (int k = 0; k < NC; k++) v[k*CW +: CW] = CW'(m_cnt[k]);
        return v;
    endfunction

    function automatic logic [NC-1:0] exp_en();
        logic [NC-1:0] v;
        for (int k = 0; k < NC; k++) v[k] = (m_cnt[k] != 0);
        return v;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ":red"},         red_accum,   exp_sums(0));
        check({tag, ":green"},       green_accum, exp_sums(1));
        check({tag, ":blue"},        blue_accum,  exp_sums(2));
        check({tag, ":count"},       count,       exp_counts());
        check({tag, ":en"},          en,          exp_en());
        check({tag, ":accum_valid"}, accum_valid, m_state == M_HOLD);
        check({tag, ":pixel_ready"}, pixel_ready, m_state == M_ACCUM);
        check({tag, ":overflow"},    overflow,    m_ovf);
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int r, input int g, input int b, input int id, input bit last);
        pixel_valid = 1'b1;
        pixel_r     = PW'(r);
        pixel_g     = PW'(g);
        pixel_b     = PW'(b);
        pixel_id    = IW'(id);
        pixel_last  = last;
        cycle();
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ce = 1'b1; start = 1'b0; pixel_valid = 1'b0; pixel_last = 1'b0;
        div_ready = 1'b0; pixel_r = '0; pixel_g = '0; pixel_b = '0; pixel_id = '0;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b1;
        cycle();

        // Frame 1: the worked example.
        start = 1'b1; cycle(); start = 1'b0;
        check_all("start");
        pix(10, 20, 30, 3, 1'b0);
        pix(5, 5, 5, 3, 1'b0);
        check_all("frame1_mid");
        check("frame1_mid:accum_valid_low", accum_valid, 1'b0);
        pix(255, 0, 1, 15, 1'b1);
        check_all("frame1_hold");
        check("lane3_r", red_accum[3*AW +: AW], 15);
        check("lane3_g", green_accum[3*AW +: AW], 25);
        check("lane3_b", blue_accum[3*AW +: AW], 35);
        check("lane3_cnt", count[3*CW +: CW], 2);
        check("lane15_r", red_accum[15*AW +: AW], 255);
        check("lane15_b", blue_accum[15*AW +: AW], 1);
        check("lane15_cnt", count[15*CW +: CW], 1);
        check("frame1_en", en, 16'h8008);
        check("frame1_valid", accum_valid, 1'b1);

        // HOLD ignores pixels and start while div_ready stays low.
        pixel_valid = 1'b1; start = 1'b1; pixel_id = 4'd7; pixel_r = 8'd99;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_all("hold_stable");
        end
        pixel_valid = 1'b0; start = 1'b0;
        div_ready = 1'b1; cycle(); div_ready = 1'b0;
        check_all("release");
        check("release:accum_valid", accum_valid, 1'b0);

        // Saturating frame on lane 0.
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 4096; i++) pix(255, 255, 255, 0, i == 4095);
        check_all("sat_hold");
        check("sat_cnt0", count[0 +: CW], 4095);
        check("sat_red0", red_accum[0 +: AW], 1044225);
        check("sat_ovf", overflow, 1'b1);
        check("sat_en", en, 16'h0001);

        // Back-to-back: release then start on the very next cycle.
        div_ready = 1'b1; cycle(); div_ready = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        check_all("b2b_start");
        check("b2b_ovf_clear", overflow, 1'b0);
        check("b2b_cnt0_clear", count[0 +: CW], 0);
        div_ready = 1'b1;
        pix(7, 8, 9, 5, 1'b0);
        div_ready = 1'b0;
        check_all("b2b_first");
        pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 2, 1'b0);
        pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 9, 1'b0);

        // Clock enable low freezes everything even with pixels toggling.
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pixel_valid = i[0] ? 1'b0 : 1'b1;
            pixel_id = 4'd2; pixel_r = 8'd50; pixel_last = 1'b1;
            cycle();
            check_all("ce_low");
        end
        pixel_last = 1'b0;
        ce = 1'b1;
        pix(1, 1, 1, 2, 1'b0);
        check_all("ce_resume");

        // Asynchronous reset between edges aborts the frame.
        #3; reset = 1'b0; #1;
        model_reset();
        check_all("async_reset");
        #2; reset = 1'b1;
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        check_all("post_reset_start");

        // Randomized frame with ce gaps, stray start/div_ready and pixel_last without valid.
        for (int i = 0; i < 300; i++) begin
            ce          = ($urandom_range(0, 3) != 0);
            pixel_valid = $urandom_range(0, 1);
            pixel_last  = (pixel_valid == 1'b0) && ($urandom_range(0, 4) == 0);
            pixel_r     = PW'($urandom);
            pixel_g     = PW'($urandom);
            pixel_b     = PW'($urandom);
            pixel_id    = IW'($urandom);
            start       = $urandom_range(0, 1);
            div_ready   = $urandom_range(0, 1);
            cycle();
            check_all("rand");
        end
        ce = 1'b1; start = 1'b0; div_ready = 1'b0;
        pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 11, 1'b1);
        check_all("rand_hold");
        check("rand_hold:valid", accum_valid, 1'b1);
        div_ready = 1'b1; cycle(); div_ready = 1'b0;
        check_all("rand_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
